// File: rtl/sdu_pkg.sv
// rtl/sdu_pkg.sv - shared encodings, state types and baud divider helper for the SDU UART
package sdu_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
        return clk_hz / (baud * ovs);
    endfunction

endpackage

// File: rtl/sdu_fifo.sv
// rtl/sdu_fifo.sv - synchronous show-ahead FIFO with occupancy level
module sdu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             pop_ok;
    logic             push_ok;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign pop_ok   = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sdu_uart_core.sv
// rtl/sdu_uart_core.sv - clock-enable UART core with oversampled RX, parity and RX/TX FIFOs
module sdu_uart_core
    import sdu_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVS        = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          rxd,
    output logic                          txd,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_vld,
    output logic                          tx_rdy,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_vld,
    input  logic                          rx_rdy,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          tx_busy,
    output logic                          err_frame,
    output logic                          err_parity,
    output logic                          err_ovr,
    input  logic                          clr_err
);

    localparam int LW  = $clog2(FIFO_DEPTH) + 1;
    localparam int DIV = calc_div(CLK_HZ, BAUD, OVS);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(OVS);
    localparam int IW  = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF_M1  = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] FULL_M1  = CW'(OVS - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

    function automatic logic par_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == PAR_ODD) ? ~^d : ^d;
    endfunction

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          rxd_meta;
    logic          rxd_sync;

    assign tick = (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt  <= '0;
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            div_cnt  <= tick ? '0 : div_cnt + 1'b1;
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
        end
    end

    rx_state_t              rx_state, rx_state_n;
    logic [CW-1:0]          rx_cnt, rx_cnt_n;
    logic [IW-1:0]          rx_idx, rx_idx_n;
    logic [DATA_BITS-1:0]   rx_shift, rx_shift_n;
    logic                   rx_par, rx_par_n;
    logic                   rx_push, rx_pop, set_frame, set_parity, set_ovr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_par   <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_shift <= rx_shift_n;
            rx_par   <= rx_par_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_par_n   = rx_par;
        rx_push    = 1'b0;
        set_frame  = 1'b0;
        set_parity = 1'b0;
        if (tick && rx_state != RX_IDLE) rx_cnt_n = rx_cnt + 1'b1;
        case (rx_state)
            RX_IDLE: begin
                if (tick && !rxd_sync) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = '0;
                end
            end
            RX_START: begin
                // Mid-bit recheck filters glitches shorter than half a bit.
                if (tick && rx_cnt == HALF_M1) begin
                    rx_cnt_n   = '0;
                    rx_idx_n   = '0;
                    rx_state_n = rxd_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick && rx_cnt == FULL_M1) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rxd_sync, rx_shift[DATA_BITS-1:1]};
                    if (rx_idx == LAST_IDX)
                        rx_state_n = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                    else
                        rx_idx_n = rx_idx + 1'b1;
                end
            end
            RX_PARITY: begin
                if (tick && rx_cnt == FULL_M1) begin
                    rx_cnt_n   = '0;
                    rx_par_n   = rxd_sync;
                    rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick && rx_cnt == FULL_M1) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                    if (!rxd_sync)
                        set_frame = 1'b1;
                    else if (PARITY != PAR_NONE && rx_par != par_of(rx_shift))
                        set_parity = 1'b1;
                    else
                        rx_push = 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    assign rx_vld  = (rx_level != '0);
    assign rx_pop  = rx_vld && rx_rdy;
    assign set_ovr = rx_push && (rx_level == FULL_LVL) && !rx_pop;

    sdu_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (rx_pop),
        .pop_data  (rx_data),
        .level     (rx_level)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_frame  <= 1'b0;
            err_parity <= 1'b0;
            err_ovr    <= 1'b0;
        end else begin
            err_frame  <= set_frame  | (err_frame  & ~clr_err);
            err_parity <= set_parity | (err_parity & ~clr_err);
            err_ovr    <= set_ovr    | (err_ovr    & ~clr_err);
        end
    end

    tx_state_t              tx_state, tx_state_n;
    logic [CW-1:0]          tx_cnt, tx_cnt_n;
    logic [IW-1:0]          tx_idx, tx_idx_n;
    logic [DATA_BITS-1:0]   tx_shift, tx_shift_n;
    logic                   tx_par, tx_par_n;
    logic                   txd_n;
    logic [DATA_BITS-1:0]   tx_head;
    logic [LW-1:0]          tx_level;
    logic                   tx_empty, tx_push, tx_pop, tx_bit_end, tx_load;

    assign tx_empty   = (tx_level == '0);
    assign tx_rdy     = (tx_level != FULL_LVL);
    assign tx_push    = tx_vld && tx_rdy;
    assign tx_busy    = (tx_state != TX_IDLE) || !tx_empty;
    assign tx_bit_end = tick && (tx_cnt == FULL_M1);
    // Loading on a tick edge makes every bit, the start bit included, exactly OVS ticks long.
    assign tx_load    = tick && !tx_empty &&
                        (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_cnt == FULL_M1));

    sdu_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (tx_push),
        .push_data (tx_data),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .level     (tx_level)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
            txd      <= txd_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        txd_n      = txd;
        tx_pop     = 1'b0;
        if (tick && tx_state != TX_IDLE) tx_cnt_n = tx_bit_end ? '0 : tx_cnt + 1'b1;
        case (tx_state)
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_n = TX_DATA;
                    tx_idx_n   = '0;
                    txd_n      = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_idx == LAST_IDX) begin
                        tx_state_n = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
                        txd_n      = (PARITY != PAR_NONE) ? tx_par : 1'b1;
                    end else begin
                        tx_idx_n   = tx_idx + 1'b1;
                        tx_shift_n = tx_shift >> 1;
                        txd_n      = tx_shift[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_n = TX_STOP;
                    txd_n      = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    tx_state_n = TX_IDLE;
                    txd_n      = 1'b1;
                end
            end
            default: ;
        endcase
        if (tx_load) begin
            tx_pop     = 1'b1;
            tx_state_n = TX_START;
            tx_cnt_n   = '0;
            tx_shift_n = tx_head;
            tx_par_n   = par_of(tx_head);
            txd_n      = 1'b0;
        end
    end

endmodule

// File: tb/tb_sdu_uart_core.sv
// tb/tb_sdu_uart_core.sv - self-checking bench for sdu_uart_core (no-parity and even-parity instances)
module tb_sdu_uart_core;

    localparam int BIT = 160;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    logic rxd0, txd0, tx_vld0, tx_rdy0, rx_vld0, rx_rdy0, tx_busy0, ef0, ep0, eo0, clr0;
    logic [7:0] tx_data0, rx_data0;
    logic [4:0] rx_level0;
    logic rxd2, rxd2_drv, loop2, txd2, tx_vld2, tx_rdy2, rx_vld2, rx_rdy2, tx_busy2, ef2, ep2, eo2, clr2;
    logic [7:0] tx_data2, rx_data2;
    logic [4:0] rx_level2;

    assign rxd2 = loop2 ? txd2 : rxd2_drv;

    sdu_uart_core #(.CLK_HZ(1_536_000), .BAUD(9600), .OVS(16), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(16)) u_dut0 (
        .clk(clk), .rstn(rstn), .rxd(rxd0), .txd(txd0), .tx_data(tx_data0), .tx_vld(tx_vld0),
        .tx_rdy(tx_rdy0), .rx_data(rx_data0), .rx_vld(rx_vld0), .rx_rdy(rx_rdy0), .rx_level(rx_level0),
        .tx_busy(tx_busy0), .err_frame(ef0), .err_parity(ep0), .err_ovr(eo0), .clr_err(clr0));

    sdu_uart_core #(.CLK_HZ(1_536_000), .BAUD(9600), .OVS(16), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(16)) u_dut2 (
        .clk(clk), .rstn(rstn), .rxd(rxd2), .txd(txd2), .tx_data(tx_data2), .tx_vld(tx_vld2),
        .tx_rdy(tx_rdy2), .rx_data(rx_data2), .rx_vld(rx_vld2), .rx_rdy(rx_rdy2), .rx_level(rx_level2),
        .tx_busy(tx_busy2), .err_frame(ef2), .err_parity(ep2), .err_ovr(eo2), .clr_err(clr2));

    int total = 0;
    int bad = 0;
    int unsigned cyc = 0;
    int unsigned vld_rise2 = 0;
    int unsigned ef_rise0 = 0;
    logic pv2 = 1'b0;
    logic pef0 = 1'b0;
    logic [7:0] q0[$];
    logic [7:0] q2[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_vld2 && !pv2) vld_rise2 = cyc;
        if (ef0 && !pef0) ef_rise0 = cyc;
        pv2 = rx_vld2;
        pef0 = ef0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Frame as line levels, index 0 = start bit, sent first; unused upper bits idle high.
    function automatic logic [11:0] frame_vec(input logic [7:0] d, input int par, input bit flip, input bit bad_stop);
        logic [11:0] v;
        logic p;
        v = '1;
        v[0] = 1'b0;
        v[8:1] = d;
        if (par == 0) begin
            v[9] = !bad_stop;
        end else begin
            p = ($countones(d) % 2 == 1);
            if (par == 1) p = !p;
            v[9] = p ^ flip;
            v[10] = !bad_stop;
        end
        return v;
    endfunction

    function automatic logic cur_txd(input int w);
        return (w == 0) ? txd0 : txd2;
    endfunction

    task automatic drive_rx(input int w, input logic [11:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            if (w == 0) rxd0 = v[i]; else rxd2_drv = v[i];
            repeat (BIT) @(negedge clk);
        end
        if (w == 0) rxd0 = 1'b1; else rxd2_drv = 1'b1;
    endtask

    task automatic check_tx(input int w, input logic [11:0] v, input int n, input string name,
                            input bit wait_start, output int unsigned start);
        int cnt;
        logic seen;
        cnt = 0;
        if (wait_start) begin
            while (cur_txd(w) !== 1'b0 && cnt < 200) begin
                @(negedge clk);
                cnt++;
            end
            chk({name, " start seen"}, cur_txd(w), 1'b0);
        end
        start = cyc;
        for (int i = 0; i < n; i++) begin
            seen = v[i];
            for (int k = 0; k < BIT; k++) begin
                if (cur_txd(w) !== v[i]) seen = cur_txd(w);
                @(negedge clk);
            end
            chk($sformatf("%s bit%0d", name, i), seen, v[i]);
        end
    endtask

    task automatic check_idle(input int w, input string tag);
        chk({tag, " txd"},       (w == 0) ? txd0 : txd2, 1'b1);
        chk({tag, " tx_rdy"},    (w == 0) ? tx_rdy0 : tx_rdy2, 1'b1);
        chk({tag, " rx_vld"},    (w == 0) ? rx_vld0 : rx_vld2, 1'b0);
        chk({tag, " rx_level"},  (w == 0) ? rx_level0 : rx_level2, 5'd0);
        chk({tag, " tx_busy"},   (w == 0) ? tx_busy0 : tx_busy2, 1'b0);
        chk({tag, " errors"},    (w == 0) ? {ef0, ep0, eo0} : {ef2, ep2, eo2}, 3'b000);
    endtask

    task automatic pulse_clr(input int w);
        if (w == 0) clr0 = 1'b1; else clr2 = 1'b1;
        @(negedge clk);
        if (w == 0) clr0 = 1'b0; else clr2 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned s, c0, c1, dly;
        int w;
        logic [7:0] b;

        rstn = 1'b0; rxd0 = 1'b1; rxd2_drv = 1'b1; loop2 = 1'b0;
        tx_data0 = '0; tx_vld0 = 1'b0; rx_rdy0 = 1'b0; clr0 = 1'b0;
        tx_data2 = '0; tx_vld2 = 1'b0; rx_rdy2 = 1'b0; clr2 = 1'b0;
        repeat (3) @(negedge clk);
        check_idle(0, "reset0");
        check_idle(2, "reset2");
        rstn = 1'b1;
        @(negedge clk);

        // Two back-to-back 0xA5 frames, no parity.
        tx_data0 = 8'hA5; tx_vld0 = 1'b1;
        repeat (2) @(negedge clk);
        tx_vld0 = 1'b0;
        chk("tx_busy after push", tx_busy0, 1'b1);
        check_tx(0, 12'b111101001010, 10, "a5 first", 1, s);
        check_tx(0, frame_vec(8'hA5, 0, 0, 0), 10, "a5 second", 0, s);
        chk("txd idle after 3200", txd0, 1'b1);
        chk("tx_busy idle after 3200", tx_busy0, 1'b0);

        // Asynchronous reset in the middle of a frame.
        tx_data0 = 8'h5A; tx_vld0 = 1'b1;
        @(negedge clk);
        tx_vld0 = 1'b0;
        repeat (600) @(negedge clk);
        rstn = 1'b0;
        #1;
        check_idle(0, "midreset");
        @(negedge clk);
        rstn = 1'b1;
        repeat (300) @(negedge clk);
        chk("no resume txd", txd0, 1'b1);
        chk("no resume busy", tx_busy0, 1'b0);

        // Even-parity loopback of 0x3C.
        loop2 = 1'b1;
        tx_data2 = 8'h3C; tx_vld2 = 1'b1;
        @(negedge clk);
        tx_vld2 = 1'b0;
        check_tx(2, 12'b110001111000, 11, "lb 3c", 1, s);
        chk("lb rx_vld", rx_vld2, 1'b1);
        chk("lb rx_data", rx_data2, 8'h3C);
        chk("lb rx_level", rx_level2, 5'd1);
        chk("lb rx_vld mid stop bit", (vld_rise2 - s >= 1660) && (vld_rise2 - s <= 1720), 1'b1);
        rx_rdy2 = 1'b1;
        @(negedge clk);
        rx_rdy2 = 1'b0;
        chk("lb popped", rx_level2, 5'd0);

        // Flipped parity bit is rejected.
        loop2 = 1'b0;
        repeat (50) @(negedge clk);
        drive_rx(2, frame_vec(8'h3C, 2, 1, 0), 11);
        repeat (20) @(negedge clk);
        chk("par err set", ep2, 1'b1);
        chk("par err no push", rx_level2, 5'd0);
        chk("par err no frame err", ef2, 1'b0);
        pulse_clr(2);
        chk("par err cleared", ep2, 1'b0);

        // Zero stop bit, then a repeat where clr_err lands on the setting cycle.
        while (cyc % 10 != 0) @(negedge clk);
        c0 = cyc;
        drive_rx(0, frame_vec(8'($urandom), 0, 0, 1), 10);
        repeat (200) @(negedge clk);
        chk("frame err set", ef0, 1'b1);
        chk("frame err no push", rx_level0, 5'd0);
        chk("frame err only", {ep0, eo0}, 2'b00);
        pulse_clr(0);
        chk("frame err cleared", ef0, 1'b0);
        while (cyc % 10 != 0) @(negedge clk);
        c1 = cyc;
        fork
            drive_rx(0, frame_vec(8'($urandom), 0, 0, 1), 10);
            begin
                while (cyc < c1 + (ef_rise0 - c0) - 1) @(negedge clk);
                clr0 = 1'b1;
                @(negedge clk);
                clr0 = 1'b0;
            end
        join
        repeat (200) @(negedge clk);
        chk("set beats clr", ef0, 1'b1);
        pulse_clr(0);
        chk("frame err cleared again", ef0, 1'b0);

        // 17 random frames into a 16-deep FIFO with no consumer.
        for (int k = 0; k < 17; k++) begin
            b = 8'($urandom);
            if (k < 16) q0.push_back(b);
            drive_rx(0, frame_vec(b, 0, 0, 0), 10);
        end
        repeat (20) @(negedge clk);
        chk("ovr level", rx_level0, 5'd16);
        chk("ovr flag", eo0, 1'b1);
        chk("ovr no frame err", ef0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            dly = $urandom_range(0, 2);
            repeat (dly) @(negedge clk);
            chk($sformatf("ovr pop%0d", k), rx_data0, q0.pop_front());
            rx_rdy0 = 1'b1;
            @(negedge clk);
            rx_rdy0 = 1'b0;
        end
        chk("ovr drained", rx_level0, 5'd0);
        pulse_clr(0);
        chk("ovr cleared", eo0, 1'b0);

        // Four-tick low glitch is a false start.
        rxd0 = 1'b0;
        repeat (40) @(negedge clk);
        rxd0 = 1'b1;
        repeat (300) @(negedge clk);
        chk("glitch no push", rx_level0, 5'd0);
        chk("glitch no error", {ef0, ep0, eo0}, 3'b000);
        b = 8'($urandom);
        drive_rx(0, frame_vec(b, 0, 0, 0), 10);
        repeat (20) @(negedge clk);
        chk("post glitch level", rx_level0, 5'd1);
        chk("post glitch data", rx_data0, b);
        rx_rdy0 = 1'b1;
        @(negedge clk);
        rx_rdy0 = 1'b0;

        // Random bytes through the parity loopback with random consumer delay.
        loop2 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tx_data2 = 8'($urandom);
            tx_vld2 = 1'b1;
            q2.push_back(tx_data2);
            @(negedge clk);
        end
        tx_vld2 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (!rx_vld2 && w < 2500) begin
                @(negedge clk);
                w++;
            end
            chk($sformatf("rand lb vld%0d", k), rx_vld2, 1'b1);
            dly = $urandom_range(0, 3);
            repeat (dly) @(negedge clk);
            chk($sformatf("rand lb data%0d", k), rx_data2, q2.pop_front());
            rx_rdy2 = 1'b1;
            @(negedge clk);
            rx_rdy2 = 1'b0;
        end
        repeat (200) @(negedge clk);
        chk("rand lb idle", tx_busy2, 1'b0);
        chk("rand lb no errors", {ef2, ep2, eo2}, 3'b000);
        chk("rand lb empty", rx_level2, 5'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
